// File: rtl/pop_stream_packer.sv
// pop_stream_packer
// Downstream stage of the LIFO/FIFO reorder block. Every popped byte is held
// for one cycle so that its last-of-group status is known, then it is pushed
// into a DEPTH-entry queue. The host drains the queue over valid/ready. There
// is no back-pressure upstream, so any entry that arrives while the queue is
// full is dropped, and the sticky overflow flag is set.
// Optional feature: define PACKER_CSUM_EN to add out_csum, which is the XOR of
// all bytes of a group. It is presented on the last entry of that group.
module pop_stream_packer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    pop_data,
   input  logic          valid_lifo,
   input  logic          done_thing,
   input  logic          valid_fifo2,
   input  logic          done_fifo2,
   output logic [7:0]    out_data,
   output logic          out_src,
   output logic          out_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW:0]   level,
   output logic [7:0]    grp_cnt,
`ifdef PACKER_CSUM_EN
   output logic [7:0]    out_csum,
`endif
   output logic          overflow
);

`ifdef PACKER_CSUM_EN
   localparam int EW = 18;
`else
   localparam int EW = 10;
`endif

   typedef enum logic [1:0] {IDLE, LIFO_GRP, FIFO_GRP} state_t;

   state_t          state;
   logic            hold_v;
   logic [7:0]      hold_byte;

   logic            in_lifo;
   logic            in_fifo;
   logic            grp_start;
   logic            grp_done;
   logic            grp_valid;
   logic            load_hold;
   logic            push_en;
   logic            push_last;
   logic            push_src;

   logic            full;
   logic            pop;
   logic            wr_ok;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [EW-1:0]   mem [DEPTH];
   logic [EW-1:0]   push_entry;
   logic [EW-1:0]   head;

   // Only the source owning the current group is listened to; done wins over valid.
   assign in_lifo   = (state == LIFO_GRP);
   assign in_fifo   = (state == FIFO_GRP);
   assign grp_start = (state == IDLE) && (valid_lifo || valid_fifo2);
   assign grp_done  = (in_lifo && done_thing) || (in_fifo && done_fifo2);
   assign grp_valid = (in_lifo && valid_lifo) || (in_fifo && valid_fifo2);
   assign load_hold = grp_start || (grp_valid && !grp_done);
   assign push_en   = hold_v && (grp_done || grp_valid);
   assign push_last = grp_done;
   assign push_src  = in_fifo;

   assign full  = (level == (AW+1)'(DEPTH));
   assign pop   = out_valid && out_ready;
   assign wr_ok = push_en && (!full || pop);

`ifdef PACKER_CSUM_EN
   logic [7:0] csum_acc;

   // Running XOR of the accepted bytes of the current group.
   always_ff @(posedge clk) begin
      if (rst)
         csum_acc <= 8'h00;
      else if (grp_start)
         csum_acc <= pop_data;
      else if (load_hold)
         csum_acc <= csum_acc ^ pop_data;
   end

   assign push_entry = {(push_last ? csum_acc : 8'h00), push_src, push_last, hold_byte};
`else
   assign push_entry = {push_src, push_last, hold_byte};
`endif

   // Group FSM and hold-valid flag: the held byte is pushed once its successor or the done strobe arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         hold_v <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_lifo) begin
                  state  <= LIFO_GRP;
                  hold_v <= 1'b1;
               end else if (valid_fifo2) begin
                  state  <= FIFO_GRP;
                  hold_v <= 1'b1;
               end
            end
            LIFO_GRP: begin
               if (done_thing) begin
                  state  <= IDLE;
                  hold_v <= 1'b0;
               end else if (valid_lifo) begin
                  hold_v <= 1'b1;
               end
            end
            FIFO_GRP: begin
               if (done_fifo2) begin
                  state  <= IDLE;
                  hold_v <= 1'b0;
               end else if (valid_fifo2) begin
                  hold_v <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               hold_v <= 1'b0;
            end
         endcase
      end
   end

   // Held byte: data only, qualified by hold_v.
   always_ff @(posedge clk) begin
      if (load_hold)
         hold_byte <= pop_data;
   end

   // Queue storage: data only, qualified by level.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= push_entry;
   end

   // Queue pointers, fill level, group counter and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         grp_cnt  <= 8'h00;
         overflow <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
         if (push_en && !wr_ok)
            overflow <= 1'b1;
         if (wr_ok && push_last)
            grp_cnt <= grp_cnt + 8'd1;
      end
   end

   // Head of queue comes straight from storage. Fields read as zero while the queue is empty.
   assign head      = mem[rd_ptr];
   assign out_valid = (level != '0);
   assign out_data  = out_valid ? head[7:0] : 8'h00;
   assign out_last  = out_valid && head[8];
   assign out_src   = out_valid && head[9];
`ifdef PACKER_CSUM_EN
   assign out_csum  = (out_valid && head[8]) ? head[17:10] : 8'h00;
`endif

endmodule

// File: tb/tb_pop_stream_packer.sv
// Testbench for pop_stream_packer: a directed vector table, hand-written
// corner sequences, and randomized traffic checked against a queue-level model.
module tb_pop_stream_packer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    pop_data;
   logic          valid_lifo;
   logic          done_thing;
   logic          valid_fifo2;
   logic          done_fifo2;
   logic [7:0]    out_data;
   logic          out_src;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;
   logic [AW:0]   level;
   logic [7:0]    grp_cnt;
   logic          overflow;
`ifdef PACKER_CSUM_EN
   logic [7:0]    out_csum;
`endif

   always #5 clk = ~clk;

   pop_stream_packer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .pop_data    (pop_data),
      .valid_lifo  (valid_lifo),
      .done_thing  (done_thing),
      .valid_fifo2 (valid_fifo2),
      .done_fifo2  (done_fifo2),
      .out_data    (out_data),
      .out_src     (out_src),
      .out_last    (out_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .level       (level),
      .grp_cnt     (grp_cnt),
`ifdef PACKER_CSUM_EN
      .out_csum    (out_csum),
`endif
      .overflow    (overflow)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (queue of entries) ----------------
   typedef struct packed {
      logic       src;
      logic       last;
      logic [7:0] data;
      logic [7:0] cs;
   } ent_t;

   ent_t       mq[$];
   int         m_grp = 0;      // 0 none, 1 LIFO group, 2 FIFO drain
   bit         m_hv  = 1'b0;
   logic [7:0] m_hold = 8'h00;
   logic [7:0] m_acc  = 8'h00;
   logic [7:0] m_gc   = 8'h00;
   bit         m_ovf  = 1'b0;

   task automatic model_update(input logic r, input logic vl, input logic dt, input logic vf,
                               input logic df, input logic rdy, input logic [7:0] pd);
      bit   do_pop, full, have_push, dn, vd;
      ent_t e;
      if (r) begin
         mq.delete();
         m_grp = 0; m_hv = 0; m_acc = 8'h00; m_gc = 8'h00; m_ovf = 0;
         return;
      end
      do_pop    = (mq.size() != 0) && rdy;
      full      = (mq.size() == DEPTH);
      have_push = 0;
      e         = '0;
      dn = (m_grp == 1) ? dt : (m_grp == 2) ? df : 1'b0;
      vd = (m_grp == 1) ? vl : (m_grp == 2) ? vf : 1'b0;
      if (m_grp == 0) begin
         if (vl) begin
            m_grp = 1; m_hold = pd; m_hv = 1; m_acc = pd;
         end else if (vf) begin
            m_grp = 2; m_hold = pd; m_hv = 1; m_acc = pd;
         end
      end else if (dn) begin
         if (m_hv) begin
            have_push = 1;
            e.src = (m_grp == 2); e.last = 1'b1; e.data = m_hold; e.cs = m_acc;
         end
         m_hv = 0; m_grp = 0;
      end else if (vd) begin
         if (m_hv) begin
            have_push = 1;
            e.src = (m_grp == 2); e.last = 1'b0; e.data = m_hold; e.cs = 8'h00;
         end
         m_hold = pd; m_hv = 1; m_acc = m_acc ^ pd;
      end
      if (do_pop)
         void'(mq.pop_front());
      if (have_push) begin
         if (full && !do_pop)
            m_ovf = 1;
         else begin
            mq.push_back(e);
            if (e.last)
               m_gc = m_gc + 8'd1;
         end
      end
   endtask

   task automatic check_model();
      ent_t h;
      bit   ev;
      ev = (mq.size() != 0);
      h  = ev ? mq[0] : '0;
      chk("mdl_out_valid", out_valid, ev);
      chk("mdl_out_data",  out_data,  h.data);
      chk("mdl_out_src",   out_src,   h.src);
      chk("mdl_out_last",  out_last,  h.last);
      chk("mdl_level",     level,     mq.size());
      chk("mdl_grp_cnt",   grp_cnt,   m_gc);
      chk("mdl_overflow",  overflow,  m_ovf);
`ifdef PACKER_CSUM_EN
      chk("mdl_out_csum",  out_csum,  h.cs);
`endif
   endtask

   task automatic drive(input logic r, input logic vl, input logic dt, input logic vf,
                        input logic df, input logic rdy, input logic [7:0] pd);
      rst = r; valid_lifo = vl; done_thing = dt; valid_fifo2 = vf;
      done_fifo2 = df; out_ready = rdy; pop_data = pd;
   endtask

   // Apply one cycle of inputs, advance the model, and check after the edge.
   task automatic step(input logic r, input logic vl, input logic dt, input logic vf,
                       input logic df, input logic rdy, input logic [7:0] pd);
      drive(r, vl, dt, vf, df, rdy, pd);
      model_update(r, vl, dt, vf, df, rdy, pd);
      @(negedge clk);
      check_model();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       r, vl, dt, vf, df, rdy;
      logic [7:0] pd;
      logic       ev;
      logic [7:0] ed;
      logic       es, el;
      logic [4:0] elvl;
      logic [7:0] egc;
      logic [7:0] ecs;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic vl, input logic dt, input logic vf,
                               input logic df, input logic rdy, input logic [7:0] pd,
                               input logic ev, input logic [7:0] ed, input logic es,
                               input logic el, input logic [4:0] elvl, input logic [7:0] egc,
                               input logic [7:0] ecs);
      vec_t v;
      v.r = r; v.vl = vl; v.dt = dt; v.vf = vf; v.df = df; v.rdy = rdy; v.pd = pd;
      v.ev = ev; v.ed = ed; v.es = es; v.el = el; v.elvl = elvl; v.egc = egc; v.ecs = ecs;
      vecs.push_back(v);
   endfunction

   initial begin
      int rp;
      drive(1'b1, 0, 0, 0, 0, 0, 8'h00);

      //   r vl dt vf df rdy pd      ev ed     es el lvl gc     cs
      add(1, 0, 0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 0, 8'd0, 8'h00); // reset state
      add(0, 1, 0, 0, 0, 1, 8'h63,  0, 8'h00, 0, 0, 0, 8'd0, 8'h00); // 'c' into hold
      add(0, 1, 0, 0, 0, 1, 8'h62,  1, 8'h63, 0, 0, 1, 8'd0, 8'h00);
      add(0, 1, 0, 0, 0, 1, 8'h61,  1, 8'h62, 0, 0, 1, 8'd0, 8'h00);
      add(0, 0, 1, 0, 0, 1, 8'h00,  1, 8'h61, 0, 1, 1, 8'd1, 8'h60); // done: 'a' is last
      add(0, 0, 0, 0, 0, 1, 8'h00,  0, 8'h00, 0, 0, 0, 8'd1, 8'h00);
      add(0, 1, 0, 0, 0, 1, 8'h30,  0, 8'h00, 0, 0, 0, 8'd1, 8'h00); // single-byte group
      add(0, 0, 1, 0, 0, 0, 8'h00,  1, 8'h30, 0, 1, 1, 8'd2, 8'h30);
      add(0, 0, 0, 0, 1, 0, 8'h00,  1, 8'h30, 0, 1, 1, 8'd2, 8'h30); // done_fifo2 in IDLE ignored
      add(0, 0, 0, 0, 0, 1, 8'h00,  0, 8'h00, 0, 0, 0, 8'd2, 8'h00);
      add(0, 0, 0, 1, 0, 0, 8'h61,  0, 8'h00, 0, 0, 0, 8'd2, 8'h00); // FIFO drain
      add(0, 0, 0, 1, 0, 0, 8'h62,  1, 8'h61, 1, 0, 1, 8'd2, 8'h00);
      add(0, 1, 0, 1, 0, 0, 8'h63,  1, 8'h61, 1, 0, 2, 8'd2, 8'h00); // valid_lifo ignored here
      add(0, 0, 0, 1, 0, 0, 8'h64,  1, 8'h61, 1, 0, 3, 8'd2, 8'h00);
      add(0, 0, 0, 0, 1, 0, 8'h00,  1, 8'h61, 1, 0, 4, 8'd3, 8'h00);
      add(0, 0, 0, 0, 0, 1, 8'h00,  1, 8'h62, 1, 0, 3, 8'd3, 8'h00);
      add(0, 0, 0, 0, 0, 1, 8'h00,  1, 8'h63, 1, 0, 2, 8'd3, 8'h00);
      add(0, 0, 0, 0, 0, 1, 8'h00,  1, 8'h64, 1, 1, 1, 8'd3, 8'h04);
      add(0, 0, 0, 0, 0, 1, 8'h00,  0, 8'h00, 0, 0, 0, 8'd3, 8'h00);
      add(0, 1, 0, 0, 0, 1, 8'h41,  0, 8'h00, 0, 0, 0, 8'd3, 8'h00);
      add(0, 1, 0, 0, 0, 1, 8'h42,  1, 8'h41, 0, 0, 1, 8'd3, 8'h00);
      add(0, 1, 1, 0, 0, 1, 8'h43,  1, 8'h42, 0, 1, 1, 8'd4, 8'h03); // done wins, 0x43 dropped
      add(0, 0, 0, 0, 0, 1, 8'h00,  0, 8'h00, 0, 0, 0, 8'd4, 8'h00);
      add(0, 0, 0, 0, 0, 1, 8'h00,  0, 8'h00, 0, 0, 0, 8'd4, 8'h00);

      foreach (vecs[i]) begin
         drive(vecs[i].r, vecs[i].vl, vecs[i].dt, vecs[i].vf, vecs[i].df, vecs[i].rdy, vecs[i].pd);
         @(negedge clk);
         chk($sformatf("tbl%0d_valid", i),    out_valid, vecs[i].ev);
         chk($sformatf("tbl%0d_data", i),     out_data,  vecs[i].ed);
         chk($sformatf("tbl%0d_src", i),      out_src,   vecs[i].es);
         chk($sformatf("tbl%0d_last", i),     out_last,  vecs[i].el);
         chk($sformatf("tbl%0d_level", i),    level,     vecs[i].elvl);
         chk($sformatf("tbl%0d_grp_cnt", i),  grp_cnt,   vecs[i].egc);
         chk($sformatf("tbl%0d_overflow", i), overflow,  1'b0);
`ifdef PACKER_CSUM_EN
         chk($sformatf("tbl%0d_csum", i),     out_csum,  vecs[i].ecs);
`endif
      end

      // ---------------- overflow: 17 pops into a 16-entry queue ----------------
      step(1, 0, 0, 0, 0, 0, 8'h00);
      for (int i = 0; i < 17; i++)
         step(0, 1, 0, 0, 0, 0, 8'h80 + 8'(i));
      step(0, 0, 1, 0, 0, 0, 8'h00);
      chk("ovf_level",   level,    5'd16);
      chk("ovf_flag",    overflow, 1'b1);
      chk("ovf_grp_cnt", grp_cnt,  8'd0);
      step(0, 1, 0, 0, 0, 0, 8'hA0);
      step(0, 1, 0, 0, 0, 1, 8'hA1);       // full: pop and push together
      chk("full_pushpop_level", level,    5'd16);
      chk("full_pushpop_head",  out_data, 8'h81);

      // ---------------- reset in the middle of a group ----------------
      step(0, 1, 0, 0, 0, 0, 8'hA2);
      step(1, 1, 0, 0, 0, 0, 8'hA3);
      chk("rst_level",     level,     5'd0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_overflow",  overflow,  1'b0);
      chk("rst_grp_cnt",   grp_cnt,   8'd0);
      step(0, 1, 0, 0, 0, 0, 8'h61);
      step(0, 1, 0, 0, 0, 0, 8'h62);
      step(0, 1, 0, 0, 0, 0, 8'h63);
      step(0, 0, 1, 0, 0, 0, 8'h00);
      step(0, 0, 0, 0, 0, 1, 8'h00);
      step(0, 0, 0, 0, 0, 1, 8'h00);
      chk("post_rst_last_data", out_data, 8'h63);
      chk("post_rst_last_flag", out_last, 1'b1);
      chk("post_rst_grp_cnt",   grp_cnt,  8'd1);
`ifdef PACKER_CSUM_EN
      chk("post_rst_csum",      out_csum, 8'h60);
`endif
      step(0, 0, 0, 0, 0, 1, 8'h00);

      // ---------------- randomized traffic against the model ----------------
      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < 800; i++) begin
            rp = (ph == 0) ? 85 : (ph == 1) ? 15 : (ph == 2) ? 50 : 3;
            step($urandom_range(0, 999) < 3,
                 $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < rp,
                 8'($urandom));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
